seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
- Display back-end stage, directly downstream of the multi-function clock top.
- Consumes its muxed sec/min/hour values, select field and alarm/timer outputs.
- Drives a 6-digit multiplexed common-anode seven-segment display (HH.MM.SS).
- Performs binary-to-BCD conversion, time-multiplexed digit scanning, frame-coherent snapshotting, blinking of the field being edited, and full-display flashing on alarm/timer events.

Parameters:
- CLK_FREQ_HZ, 1000: input clock frequency in Hz; must be >= 1000.
- DIGIT_HZ, 500: digit-advance rate; digit period DIG_DIV = CLK_FREQ_HZ/DIGIT_HZ cycles; DIG_DIV must be >= 1.
- BLINK_HZ, 2: blink rate; phase toggles every HALF_DIV = CLK_FREQ_HZ/(2*BLINK_HZ) cycles; HALF_DIV must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- sec_in  in  6  seconds, binary.
- min_in  in  6  minutes, binary.
- hour_in  in  5  hours, binary.
- select  in  2  field being edited: 0 none, 1 sec, 2 min, 3 hour.
- attention  in  1  OR of alarm_out and timer_out; flashes the whole display.
- an  out  6  digit enables, active-low; an[0] = sec ones … an[5] = hour tens.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset (async assert, sync release), all internal state cleared:
  - div_cnt = 0, blink_cnt = 0, idx = 0, blink_phase = 0 (visible).
  - Snapshot registers = 0.
  - Outputs: an = 6'b111111, seg = 7'b1111111, dp = 1.
- Digit tick:
  - div_cnt counts 0..DIG_DIV-1 and wraps; tick is asserted on the cycle div_cnt == DIG_DIV-1.
  - On a tick, idx advances 0→1→…→5→0.
- Snapshot:
  - On the tick where idx == 5 (idx wraps to 0), sec_in/min_in/hour_in are latched into the snapshot.
  - All six digits of one frame come from one snapshot, so there is no tearing.
  - Until the first wrap after reset, the snapshot holds 00:00:00.
- Decode:
  - Per field: tens = value/10, ones = value%10, built with compare/subtract logic.
  - No divider IP.
- Range check:
  - sec or min > 59, or hour > 23: both digits of that field show a dash (7'b0111111).
  - This range check has priority over BCD decode.
- Segment codes, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Blink:
  - blink_cnt counts 0..HALF_DIV-1; on wrap, blink_phase toggles.
  - blink_phase = 1 means the off half.
- Blanking priority (an forced to 1, seg = blank, dp = 1):
  1. attention = 1 and blink_phase = 1: all digits blank.
  2. Else, select ≠ 0 and blink_phase = 1: the two digits of the selected field blank; other digits display normally.
  3. Else: normal display.
  - attention overrides select when both are active.
- dp: lit (0) on idx 2 and idx 4 as the field separator, unless blanked.
- Output timing:
  - an, seg, dp are registered and reflect idx/snapshot/blink state with exactly 1 cycle latency.
  - Exactly one an bit is low at any time, except while blanked or in reset.
- select and attention are sampled every cycle; there is no snapshot for them. A change takes effect on the next output register update.
- Reset asserted mid-frame: outputs go to all-off immediately (asynchronously). After release, scanning restarts at idx 0.

Optional Feature:
- Macro: HOUR_LEADING_BLANK_EN.
- Defined: when the snapshot hour < 10 and the hour is in range, the hour-tens digit (idx 5) shows blank instead of '0'. an[5] is still driven low in its slot so scan timing and duty are unchanged.
- Undefined: the hour-tens digit always shows its decoded value, including '0'.

Test Plan:
- Reset, then release with inputs 12:34:56, defaults:
  - Outputs are all-off during reset.
  - After the first frame wrap, idx 0..5 show 6,5,4,3,2,1.
  - seg for '6' = 0000010.
  - dp is low only while an = 6'b111011 and an = 6'b101111.
- Input changes from 12:34:56 to 12:34:57 mid-frame (idx = 2):
  - The current frame still shows 56.
  - The next frame shows 57 on an[0] (seg 1111000).
- select = 2, BLINK_HZ = 2, CLK 1000:
  - an[3:2] stay high for 250 cycles, then scan normally for 250 cycles.
  - The other digits are unaffected.
- attention = 1 with select = 3:
  - All an bits are high during the off half; all digits are visible during the on half.
  - No selective hour blink occurs.
- sec_in = 60, hour_in = 24:
  - Sec digits and hour digits show 0111111.
  - Min digits show the correct value.
- Compile with HOUR_LEADING_BLANK_EN, hour_in = 7:
  - During the an[5] slot, seg = 1111111.
  - During the an[4] slot, seg = 1111000.
  - Without the macro, the an[5] slot shows 1000000.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Six-digit multiplexed seven-segment scanner for HH.MM.SS with frame snapshot, field blink and attention flash.
// Optional build macro HOUR_LEADING_BLANK_EN suppresses a leading '0' on the hour-tens digit.
module seven_seg_scanner #(
  parameter int CLK_FREQ_HZ = 1000,
  parameter int DIGIT_HZ    = 500,
  parameter int BLINK_HZ    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [4:0] hour_in,
  input  logic [1:0] select,
  input  logic       attention,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIG_DIV  = CLK_FREQ_HZ / DIGIT_HZ;
  localparam int HALF_DIV = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int DW = (DIG_DIV  > 1) ? $clog2(DIG_DIV)  : 1;
  localparam int BW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  localparam logic [DW-1:0] DIG_LAST   = DW'(DIG_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          blink_phase_q, blink_phase_d;
  logic [5:0]    snap_sec_q, snap_sec_d;
  logic [5:0]    snap_min_q, snap_min_d;
  logic [4:0]    snap_hour_q, snap_hour_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic [5:0]    fieldVal;
  logic          fieldBad;
  logic [1:0]    fieldSel;
  logic [7:0]    fieldBcd;
  logic [3:0]    digit;
  logic          blankNow;

  // Binary-to-BCD by repeated compare/subtract; six steps cover the 0..63 input range.
  function automatic logic [7:0] toBcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (r >= 6'd10) begin
        r = r - 6'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  function automatic logic [6:0] segCode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign tick = (div_cnt_q == DIG_LAST);

  always_comb begin
    div_cnt_d     = tick ? '0 : div_cnt_q + 1'b1;
    idx_d         = idx_q;
    if (tick) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    blink_cnt_d   = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = (blink_cnt_q == BLINK_LAST) ? ~blink_phase_q : blink_phase_q;
    snap_sec_d    = snap_sec_q;
    snap_min_d    = snap_min_q;
    snap_hour_d   = snap_hour_q;
    // Latch a fresh snapshot only at the frame boundary so a frame never mixes two times.
    if (tick && idx_q == 3'd5) begin
      snap_sec_d  = sec_in;
      snap_min_d  = min_in;
      snap_hour_d = hour_in;
    end
  end

  always_comb begin
    fieldVal = snap_sec_q;
    fieldBad = (snap_sec_q > 6'd59);
    fieldSel = 2'd1;
    case (idx_q)
      3'd2, 3'd3: begin
        fieldVal = snap_min_q;
        fieldBad = (snap_min_q > 6'd59);
        fieldSel = 2'd2;
      end
      3'd4, 3'd5: begin
        fieldVal = {1'b0, snap_hour_q};
        fieldBad = (snap_hour_q > 5'd23);
        fieldSel = 2'd3;
      end
      default: ;
    endcase
    fieldBcd = toBcd(fieldVal);
    digit    = idx_q[0] ? fieldBcd[7:4] : fieldBcd[3:0];

    seg_d = fieldBad ? SEG_DASH : segCode(digit);
`ifdef HOUR_LEADING_BLANK_EN
    if (idx_q == 3'd5 && !fieldBad && snap_hour_q < 5'd10) seg_d = SEG_BLANK;
`endif
    an_d = ~(6'b000001 << idx_q);
    dp_d = !(idx_q == 3'd2 || idx_q == 3'd4);

    // Attention flashes everything and therefore dominates the per-field edit blink.
    blankNow = blink_phase_q && (attention || (select != 2'd0 && select == fieldSel));
    if (blankNow) begin
      an_d  = 6'b111111;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      idx_q         <= 3'd0;
      blink_phase_q <= 1'b0;
      snap_sec_q    <= 6'd0;
      snap_min_q    <= 6'd0;
      snap_hour_q   <= 5'd0;
      an_q          <= 6'b111111;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      div_cnt_q     <= div_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      idx_q         <= idx_d;
      blink_phase_q <= blink_phase_d;
      snap_sec_q    <= snap_sec_d;
      snap_min_q    <= snap_min_d;
      snap_hour_q   <= snap_hour_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed scenarios plus random input changes, checked every cycle
// against an arithmetic model of scan position, blink phase and frame snapshot.
module tb_seven_seg_scanner;

  localparam int CLK_FREQ_HZ = 1000;
  localparam int DIGIT_HZ    = 500;
  localparam int BLINK_HZ    = 2;
  localparam int DIG_DIV     = CLK_FREQ_HZ / DIGIT_HZ;
  localparam int HALF_DIV    = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int FRAME       = 6 * DIG_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] secIn;
  logic [5:0] minIn;
  logic [4:0] hourIn;
  logic [1:0] select;
  logic       attention;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad   = 0;
  int cycleN;
  int snapVal [3];

  seven_seg_scanner #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .DIGIT_HZ   (DIGIT_HZ),
    .BLINK_HZ   (BLINK_HZ)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sec_in   (secIn),
    .min_in   (minIn),
    .hour_in  (hourIn),
    .select   (select),
    .attention(attention),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (model cycle %0d)", tag, actual, expected, cycleN);
    end
  endtask

  function automatic logic [6:0] digitSeg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // One clock: predict the outputs from the pre-edge model state, advance the model, then compare.
  task automatic stepCycle(input string tag);
    int idx, field, val, limit, phase;
    logic [5:0] expAn;
    logic [6:0] expSeg;
    logic       expDp;
    idx   = (cycleN / DIG_DIV) % 6;
    phase = (cycleN / HALF_DIV) % 2;
    field = idx / 2;
    val   = snapVal[field];
    limit = (field == 2) ? 23 : 59;
    if (val > limit) expSeg = 7'b0111111;
    else expSeg = digitSeg((idx % 2 == 1) ? val / 10 : val % 10);
`ifdef HOUR_LEADING_BLANK_EN
    if (idx == 5 && val <= limit && val < 10) expSeg = 7'b1111111;
`endif
    expAn = 6'h3F & ~(6'(1) << idx);
    expDp = (idx == 2 || idx == 4) ? 1'b0 : 1'b1;
    if (phase == 1 && (attention || (select != 0 && int'(select) == field + 1))) begin
      expAn  = 6'h3F;
      expSeg = 7'b1111111;
      expDp  = 1'b1;
    end
    if (cycleN % FRAME == FRAME - 1) begin
      snapVal[0] = secIn;
      snapVal[1] = minIn;
      snapVal[2] = hourIn;
    end
    cycleN++;
    @(posedge clk);
    #1;
    checkOutput({tag, ".an"},  32'(an),  32'(expAn));
    checkOutput({tag, ".seg"}, 32'(seg), 32'(expSeg));
    checkOutput({tag, ".dp"},  32'(dp),  32'(expDp));
  endtask

  task automatic applyStimulus(input string tag, input int count, input bit randomize);
    for (int i = 0; i < count; i++) begin
      if (randomize && $urandom_range(0, 6) == 0) begin
        secIn  = 6'($urandom_range(0, 63));
        minIn  = 6'($urandom_range(0, 63));
        hourIn = 5'($urandom_range(0, 31));
        select = 2'($urandom_range(0, 3));
        attention = ($urandom_range(0, 9) == 0);
      end
      stepCycle(tag);
    end
  endtask

  task automatic checkAllOff(input string tag);
    checkOutput({tag, ".an"},  32'(an),  32'h3F);
    checkOutput({tag, ".seg"}, 32'(seg), 32'h7F);
    checkOutput({tag, ".dp"},  32'(dp),  32'h1);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    reset   = 1'b1;
    cycleN  = 0;
    snapVal = '{0, 0, 0};
  endtask

  initial begin
    reset     = 1'b0;
    secIn     = 6'd56;
    minIn     = 6'd34;
    hourIn    = 5'd12;
    select    = 2'd0;
    attention = 1'b0;
    cycleN    = 0;
    snapVal   = '{0, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    checkAllOff("reset");
    releaseReset();

    applyStimulus("frame", 40, 1'b0);
    secIn = 6'd57;
    applyStimulus("midframe", 30, 1'b0);

    select = 2'd2;
    applyStimulus("blinkMin", 600, 1'b0);

    select    = 2'd3;
    attention = 1'b1;
    applyStimulus("attention", 600, 1'b0);

    select    = 2'd0;
    attention = 1'b0;
    secIn     = 6'd60;
    hourIn    = 5'd24;
    applyStimulus("range", 30, 1'b0);

    secIn  = 6'd5;
    hourIn = 5'd7;
    applyStimulus("hour7", 30, 1'b0);

    #3 reset = 1'b0;
    #1;
    checkAllOff("midReset");
    repeat (2) @(posedge clk);
    releaseReset();
    applyStimulus("afterReset", 30, 1'b0);

    applyStimulus("random", 3000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
